// File: rtl/uc_dispatch_arbiter.sv
// Round-robin consumer for the unit clause queues. Pops at most one queue per cycle into a
// single-entry output register with a valid/ready handshake, and drops null literals.
module uc_dispatch_arbiter #(
    parameter int NUM_Q    = 4,
    parameter int DATA_LEN = 512,
    parameter int CNT_W    = 16,
    localparam int LIT_W   = $clog2(DATA_LEN),
    localparam int QW      = $clog2(NUM_Q)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_Q-1:0]        q_empty,
    input  logic signed [LIT_W-1:0] q_data [NUM_Q],
    output logic [NUM_Q-1:0]        q_pop,
    output logic                    uc_valid,
    output logic signed [LIT_W-1:0] uc_lit,
    output logic [QW-1:0]           uc_src,
    input  logic                    uc_ready,
    input  logic                    flush,
    output logic                    busy,
    output logic [CNT_W-1:0]        dispatch_cnt,
    output logic [CNT_W-1:0]        drop_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state, state_next;
    logic [QW-1:0] rr_ptr;
    logic [QW-1:0] grant_idx;
    logic          grant_found;
    logic          grant_null;
    logic          xfer;
    logic          can_load;

    assign uc_valid = (state == FULL);
    assign xfer     = uc_valid && uc_ready;
    assign can_load = (state == EMPTY) || xfer;
    assign busy     = uc_valid || !(&q_empty);

    always_comb begin
        logic [QW-1:0] idx;
        idx         = '0;
        q_pop       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        grant_null  = 1'b0;
        state_next  = state;
        if (can_load && !flush && !rst) begin
            // Wrap-around search relies on NUM_Q being a power of two.
            for (int unsigned k = 0; k < NUM_Q; k++) begin
                idx = rr_ptr + QW'(k);
                if (!grant_found && !q_empty[idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
        if (grant_found) begin
            q_pop[grant_idx] = 1'b1;
            grant_null       = (q_data[grant_idx] == '0);
        end
        if (xfer)
            state_next = EMPTY;
        if (grant_found && !grant_null)
            state_next = FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            rr_ptr       <= '0;
            uc_lit       <= '0;
            uc_src       <= '0;
            dispatch_cnt <= '0;
            drop_cnt     <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            rr_ptr <= '0;
        end else begin
            state <= state_next;
            if (xfer)
                dispatch_cnt <= dispatch_cnt + CNT_W'(1);
            if (grant_found) begin
                rr_ptr <= grant_idx + QW'(1);
                if (grant_null) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end else begin
                    uc_lit <= q_data[grant_idx];
                    uc_src <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_uc_dispatch_arbiter.sv
// Directed bench for uc_dispatch_arbiter: queue contents come from small per-queue lists,
// expected grants/literals/counters are hand-derived per step.
module tb_uc_dispatch_arbiter;

    localparam int NUM_Q = 4;
    localparam int LIT_W = 9;
    localparam int CNT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_Q-1:0]        q_empty;
    logic signed [LIT_W-1:0] q_data [NUM_Q];
    logic [NUM_Q-1:0]        q_pop;
    logic                    uc_valid;
    logic signed [LIT_W-1:0] uc_lit;
    logic [1:0]              uc_src;
    logic                    uc_ready;
    logic                    flush;
    logic                    busy;
    logic [CNT_W-1:0]        dispatch_cnt;
    logic [CNT_W-1:0]        drop_cnt;

    int          qm [NUM_Q][$];
    logic [NUM_Q-1:0] pop_seen;
    int          errors = 0;
    int          checks = 0;

    uc_dispatch_arbiter #(.NUM_Q(NUM_Q), .DATA_LEN(512), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .q_empty(q_empty), .q_data(q_data), .q_pop(q_pop),
        .uc_valid(uc_valid), .uc_lit(uc_lit), .uc_src(uc_src), .uc_ready(uc_ready),
        .flush(flush), .busy(busy), .dispatch_cnt(dispatch_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic update_q();
        for (int i = 0; i < NUM_Q; i++) begin
            q_empty[i] = (qm[i].size() == 0);
            q_data[i]  = (qm[i].size() != 0) ? LIT_W'(qm[i][0]) : '0;
        end
    endtask

    // One clock: present queue heads, record the grant, then pop the granted head after the edge.
    task automatic cycle();
        int dummy;
        update_q();
        #1;
        pop_seen = q_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_Q; i++)
            if (pop_seen[i] && qm[i].size() != 0) dummy = qm[i].pop_front();
        update_q();
        @(negedge clk);
    endtask

    initial begin
        int exp_lit [5];
        int exp_pop [5];
        rst = 1'b1; flush = 1'b0; uc_ready = 1'b0;
        update_q();
        @(negedge clk);

        // Reset and idle
        cycle(); cycle();
        check("rst_pop", q_pop, 0);
        rst = 1'b0;
        cycle();
        check("idle_pop", pop_seen, 0);
        check("idle_valid", uc_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_lit", uc_lit, 0);
        check("idle_disp", dispatch_cnt, 0);
        check("idle_drop", drop_cnt, 0);

        // Single queue streaming at full rate
        qm[1] = '{5, -7, 9};
        uc_ready = 1'b1;
        exp_lit[0] = 5; exp_lit[1] = -7; exp_lit[2] = 9;
        for (int n = 0; n < 3; n++) begin
            cycle();
            check("sq_pop", pop_seen, 4'b0010);
            check("sq_valid", uc_valid, 1);
            check("sq_lit", uc_lit, exp_lit[n]);
            check("sq_src", uc_src, 1);
            check("sq_disp", dispatch_cnt, n);
        end
        cycle();
        check("sq_drain_pop", pop_seen, 0);
        check("sq_drain_valid", uc_valid, 0);
        check("sq_disp_final", dispatch_cnt, 3);

        // Flush with nothing held realigns the pointer to 0
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl0_disp", dispatch_cnt, 3);

        // Round-robin over all four queues
        qm[0] = '{10, 10}; qm[1] = '{20}; qm[2] = '{30}; qm[3] = '{40};
        exp_pop[0] = 1; exp_pop[1] = 2; exp_pop[2] = 4; exp_pop[3] = 8; exp_pop[4] = 1;
        exp_lit[0] = 10; exp_lit[1] = 20; exp_lit[2] = 30; exp_lit[3] = 40; exp_lit[4] = 10;
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("rr_pop", pop_seen, exp_pop[n]);
            check("rr_lit", uc_lit, exp_lit[n]);
            check("rr_src", uc_src, (n == 4) ? 0 : n);
        end
        cycle();
        check("rr_drain_valid", uc_valid, 0);
        check("rr_disp", dispatch_cnt, 8);

        // Backpressure: hold -3 for four cycles, then release (rr_ptr is 1 here)
        qm[1] = '{-3}; qm[2] = '{6};
        uc_ready = 1'b0;
        cycle();
        check("bp_load_pop", pop_seen, 4'b0010);
        check("bp_load_lit", uc_lit, -3);
        for (int n = 0; n < 4; n++) begin
            cycle();
            check("bp_hold_pop", pop_seen, 0);
            check("bp_hold_valid", uc_valid, 1);
            check("bp_hold_lit", uc_lit, -3);
            check("bp_hold_busy", busy, 1);
        end
        check("bp_hold_disp", dispatch_cnt, 8);
        uc_ready = 1'b1;
        cycle();
        check("bp_rel_pop", pop_seen, 4'b0100);
        check("bp_rel_disp", dispatch_cnt, 9);
        check("bp_rel_lit", uc_lit, 6);
        check("bp_rel_src", uc_src, 2);
        cycle();
        check("bp_drain_disp", dispatch_cnt, 10);
        check("bp_drain_valid", uc_valid, 0);

        // Null literal is dropped (rr_ptr is 3, only q2 non-empty)
        qm[2] = '{0, 12};
        cycle();
        check("nd_pop0", pop_seen, 4'b0100);
        check("nd_valid0", uc_valid, 0);
        check("nd_drop", drop_cnt, 1);
        cycle();
        check("nd_pop1", pop_seen, 4'b0100);
        check("nd_lit", uc_lit, 12);
        check("nd_src", uc_src, 2);
        check("nd_drop_keep", drop_cnt, 1);
        cycle();
        check("nd_disp", dispatch_cnt, 11);

        // Flush while FULL with rr_ptr=3 and ready=1
        qm[2] = '{8};
        uc_ready = 1'b0;
        cycle();
        check("fl_load_lit", uc_lit, 8);
        qm[3] = '{50}; qm[0] = '{60};
        flush = 1'b1; uc_ready = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_pop", pop_seen, 0);
        check("fl_valid", uc_valid, 0);
        check("fl_disp", dispatch_cnt, 11);
        uc_ready = 1'b0;
        cycle();
        check("fl_rr_pop", pop_seen, 4'b0001);
        check("fl_rr_lit", uc_lit, 60);

        // Reset while holding a literal with a queue still non-empty
        rst = 1'b1; uc_ready = 1'b1;
        cycle();
        check("mr_pop", pop_seen, 0);
        check("mr_valid", uc_valid, 0);
        check("mr_lit", uc_lit, 0);
        check("mr_disp", dispatch_cnt, 0);
        check("mr_drop", drop_cnt, 0);
        rst = 1'b0;
        cycle();
        check("mr_after_pop", pop_seen, 4'b1000);
        check("mr_after_lit", uc_lit, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uc_dispatch_arbiter.md
Name: uc_dispatch_arbiter

Overview:
- Consumer side of the unit clause queues (UCQ) in the lookup unit.
- Watches the empty flags of NUM_Q queues and pops one queue per cycle in round-robin order.
- Captures the popped literal into a single-entry output register and hands it to the process engine with a valid/ready handshake.
- Drops null literals (value 0), supports a synchronous flush, and keeps dispatch and drop counters for debug and perf.

Parameters:
- NUM_Q, 4, number of unit clause queues arbitrated; power of 2, at least 2.
- DATA_LEN, 512, literal space; LIT_W = $clog2(DATA_LEN) is the signed literal width.
- CNT_W, 16, width of the dispatch and drop counters.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- q_empty  input  NUM_Q  per-queue empty flag.
- q_data  input  NUM_Q x LIT_W signed  per-queue pop data. Valid in the same cycle as q_pop[i] when q_empty[i]=0 (combinational head read).
- q_pop  output  NUM_Q  one-hot-or-zero pop strobe.
- uc_valid  output  1  output register holds a literal.
- uc_lit  output  LIT_W signed  dispatched literal.
- uc_src  output  $clog2(NUM_Q)  index of the queue the literal came from.
- uc_ready  input  1  engine accepts; a transfer occurs when uc_valid && uc_ready.
- flush  input  1  discard the held literal and reset the round-robin pointer.
- busy  output  1  uc_valid OR any q_empty bit is 0.
- dispatch_cnt  output  CNT_W  count of completed transfers; wraps.
- drop_cnt  output  CNT_W  count of null literals popped and discarded; wraps.

Behaviour:
- Reset values: q_pop=0, uc_valid=0, uc_lit=0, uc_src=0, rr_ptr=0, dispatch_cnt=0, drop_cnt=0. State is EMPTY.
- FSM has two states, driven by the output register.
  - EMPTY: uc_valid=0.
  - FULL: uc_valid=1; uc_lit and uc_src are stable until the transfer.
- can_load = (state==EMPTY) OR (uc_valid && uc_ready).
- Grant logic (combinational):
  - When can_load && !flush && !rst, search from rr_ptr upward, modulo NUM_Q, for the first i with q_empty[i]=0.
  - If found, assert q_pop[i]=1 and no other bit. Otherwise q_pop=0.
  - q_pop is never asserted for an empty queue.
- Capture at the clock edge after a grant g:
  - rr_ptr <= (g+1) mod NUM_Q.
  - If q_data[g] != 0: uc_lit <= q_data[g], uc_src <= g, state <= FULL.
  - If q_data[g] == 0: drop_cnt++. State becomes EMPTY if a transfer also happened this cycle, otherwise it stays as it was.
- Transfer without a grant (uc_valid && uc_ready, all queues empty): state <= EMPTY. uc_lit and uc_src hold their old values.
- dispatch_cnt increments on every cycle with uc_valid && uc_ready && !flush.
- Throughput: one literal per cycle while uc_ready=1 and any queue is non-empty (back-to-back pop and transfer).
- Latency: pop in cycle N gives uc_valid in cycle N+1.
- Backpressure: in FULL with uc_ready=0, q_pop=0 and rr_ptr holds.
- flush has priority over everything:
  - q_pop=0, state <= EMPTY, rr_ptr <= 0.
  - No counter changes, even if uc_ready=1 that cycle.
  - Queues are not drained by this block.
- Reset mid-operation: all state returns to reset values on the next edge. q_pop is 0 while rst=1.
- Negative literals pass through unchanged (sign = polarity). Only exactly 0 is dropped.
- The rr_ptr rule gives fairness: a continuously non-empty queue waits at most NUM_Q-1 grants.

Test Plan:
- Reset and idle: rst for 2 cycles, all q_empty=1 -> q_pop=0, uc_valid=0, busy=0, both counters 0.
- Single queue, ready=1: q1 holds {5,-7,9} -> q_pop=0010 for 3 consecutive cycles. uc_lit is 5,-7,9 on cycles N+1..N+3, all with uc_src=1. dispatch_cnt=3.
- Round-robin: all 4 queues non-empty, q_data = 10,20,30,40, ready=1 -> grant order 0,1,2,3,0. uc_lit sequence 10,20,30,40,10.
- Backpressure: uc_valid=1 with lit=-3 and ready=0 for 4 cycles -> q_pop=0 and uc_lit stays -3. Then ready=1 -> transfer, a new pop in the same cycle, dispatch_cnt +1.
- Null drop: q2 head=0 then 12 -> first pop gives no uc_valid and drop_cnt=1. Second pop gives uc_lit=12, uc_src=2.
- Flush: FULL holding 8 with rr_ptr=3, assert flush with ready=1 -> next cycle uc_valid=0, rr_ptr=0, dispatch_cnt unchanged, no pop during the flush cycle.
